// File: rtl/pair_resolver.sv
// pair_resolver: owns card visibility, matched set and current player.
// Optional turn limit: define PAIR_RESOLVER_TURN_TIMEOUT_EN.
module pair_resolver #(
  parameter int NCARDS = 16,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_pick,
  input  logic [7:0]        card_idx,
  input  logic              turn_done,
  input  logic              pair_match,
  input  logic [7:0]        sel1,
  input  logic [7:0]        sel2,
  input  logic              game_over,
  output logic              player,
  output logic [NCARDS-1:0] revealed,
  output logic [NCARDS-1:0] matched,
  output logic              busy
);

  localparam int IW = (NCARDS > 1) ? $clog2(NCARDS) : 1;
  localparam logic [7:0] NC = 8'(NCARDS);

  typedef enum logic [1:0] {
    IDLE, ONE_UP, HOLD, DONE
  } state_t;

  state_t      state;
  logic [31:0] cnt;

  logic [NCARDS-1:0] pick_bit;
  logic [NCARDS-1:0] s1_bit;
  logic [NCARDS-1:0] s2_bit;
  logic [NCARDS-1:0] rev_pk;
  logic              pick_ok;
  logic              pair_ok;
  logic              tmo;

  // One-hot decode of the indices, with range and legality checks
  always_comb begin
    pick_bit = '0;
    s1_bit   = '0;
    s2_bit   = '0;
    if (card_idx < NC) pick_bit[card_idx[IW-1:0]] = 1'b1;
    if (sel1 < NC) s1_bit[sel1[IW-1:0]] = 1'b1;
    if (sel2 < NC) s2_bit[sel2[IW-1:0]] = 1'b1;
    pick_ok = card_pick
            && (|(pick_bit & ~matched & ~revealed));
    rev_pk  = pick_ok ? (revealed | pick_bit) : revealed;
    pair_ok = pair_match && (sel1 != sel2)
            && (sel1 < NC) && (sel2 < NC);
  end

`ifdef PAIR_RESOLVER_TURN_TIMEOUT_EN
  logic [31:0] tmr;
  logic        active;

  assign active = (state == IDLE) || (state == ONE_UP);
  assign tmo = active
             && (tmr == 32'(TIMEOUT_CYCLES - 1))
             && !((state == ONE_UP) && turn_done);

  // Turn timer: runs in IDLE/ONE_UP, restarts whenever IDLE is re-entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr <= '0;
    end else if (game_over || state == DONE) begin
      tmr <= tmr;
    end else if (!active || tmo
                 || (state == ONE_UP && turn_done)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 32'd1;
    end
  end
`else
  // No turn limit: a turn waits indefinitely
  assign tmo = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Turn/visibility state machine with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      player   <= 1'b0;
      revealed <= '0;
      matched  <= '0;
      busy     <= 1'b0;
    end else if (state != DONE && game_over) begin
      state <= DONE;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (tmo) begin
            revealed <= '0;
            player   <= ~player;
          end else if (pick_ok) begin
            revealed <= rev_pk;
            state    <= ONE_UP;
          end
        end
        ONE_UP: begin
          if (turn_done && pair_ok) begin
            matched  <= matched | s1_bit | s2_bit;
            revealed <= rev_pk & ~(s1_bit | s2_bit);
            state    <= IDLE;
          end else if (turn_done) begin
            revealed <= rev_pk;
            cnt      <= 32'(HOLD_CYCLES - 1);
            busy     <= 1'b1;
            state    <= HOLD;
          end else if (tmo) begin
            revealed <= '0;
            player   <= ~player;
            state    <= IDLE;
          end else begin
            revealed <= rev_pk;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            revealed <= '0;
            player   <= ~player;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DONE: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_resolver.sv
// tb_pair_resolver: scenario tasks against a hand-stepped model.
// Expected snapshots are queued at stimulus time, popped after the edge.
module tb_pair_resolver;

  localparam int N = 16;

  typedef struct packed {
    logic         ply;
    logic         bsy;
    logic [N-1:0] mat;
    logic [N-1:0] rev;
  } snap_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         card_pick = 1'b0;
  logic [7:0]   card_idx = '0;
  logic         turn_done = 1'b0;
  logic         pair_match = 1'b0;
  logic [7:0]   sel1 = '0;
  logic [7:0]   sel2 = '0;
  logic         game_over = 1'b0;
  logic         player;
  logic         busy;
  logic [N-1:0] revealed;
  logic [N-1:0] matched;

  int    run = 0;
  int    failed = 0;
  snap_t sb[$];
  snap_t m;
  snap_t got;
  snap_t want;

  always #5 clk = ~clk;

  pair_resolver #(
    .NCARDS(N),
    .HOLD_CYCLES(4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .card_pick(card_pick),
    .card_idx(card_idx),
    .turn_done(turn_done),
    .pair_match(pair_match),
    .sel1(sel1),
    .sel2(sel2),
    .game_over(game_over),
    .player(player),
    .revealed(revealed),
    .matched(matched),
    .busy(busy)
  );

  function automatic snap_t obs();
    return {player, busy, matched, revealed};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input logic [7:0] i);
    card_pick = 1'b1;
    card_idx  = i;
    tick();
    card_pick = 1'b0;
  endtask

  task automatic done(input logic pm, input logic [7:0] a,
                      input logic [7:0] b);
    turn_done  = 1'b1;
    pair_match = pm;
    sel1       = a;
    sel2       = b;
    tick();
    turn_done  = 1'b0;
    pair_match = 1'b0;
  endtask

  task automatic test_reset();
    m = '0;
    sb.push_back(m);
    #2;
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL reset: got %h want %h", got, want);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_pair();
    m.rev[3] = 1'b1;
    sb.push_back(m);
    pick(8'd3);
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL pair_pick3: got %h want %h", got, want);
    end
    m.rev[7] = 1'b1;
    sb.push_back(m);
    pick(8'd7);
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL pair_pick7: got %h want %h", got, want);
    end
    m.mat = 16'h0088;
    m.rev = '0;
    sb.push_back(m);
    done(1'b1, 8'd3, 8'd7);
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL pair_match: got %h want %h", got, want);
    end
  endtask

  task automatic test_mismatch();
    pick(8'd1);
    pick(8'd2);
    m.rev = 16'h0006;
    m.bsy = 1'b1;
    sb.push_back(m);
    done(1'b0, 8'd1, 8'd2);
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL mm_busy_first: got %h want %h", got, want);
    end
    for (int k = 2; k <= 4; k++) begin
      if (k == 2) begin
        card_pick = 1'b1;
        card_idx  = 8'd4;
      end
      sb.push_back(m);
      tick();
      card_pick = 1'b0;
      want = sb.pop_front(); got = obs(); run++;
      if (got !== want) begin
        failed++;
        $display("FAIL mm_hold_c%0d: got %h want %h", k, got, want);
      end
    end
    m.bsy = 1'b0;
    m.rev = '0;
    m.ply = 1'b1;
    sb.push_back(m);
    tick();
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL mm_release: got %h want %h", got, want);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] idx [4];
    idx[0] = 8'd20;
    idx[1] = 8'd3;
    idx[2] = 8'd5;
    idx[3] = 8'd5;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) m.rev[5] = 1'b1;
      sb.push_back(m);
      pick(idx[i]);
      want = sb.pop_front(); got = obs(); run++;
      if (got !== want) begin
        failed++;
        $display("FAIL inv_pick%0d idx %0d: got %h want %h",
                 i, idx[i], got, want);
      end
    end
  endtask

  task automatic test_same_sel();
    m.bsy = 1'b1;
    sb.push_back(m);
    done(1'b1, 8'd5, 8'd5);
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL samesel_hold: got %h want %h", got, want);
    end
    repeat (3) tick();
    m.bsy = 1'b0;
    m.rev = '0;
    m.ply = 1'b0;
    sb.push_back(m);
    tick();
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL samesel_release: got %h want %h", got, want);
    end
  endtask

  task automatic test_same_cycle();
    pick(8'd9);
    card_pick = 1'b1;
    card_idx  = 8'd10;
    m.mat = m.mat | 16'h0600;
    m.rev = '0;
    sb.push_back(m);
    done(1'b1, 8'd9, 8'd10);
    card_pick = 1'b0;
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL samecyc_match: got %h want %h", got, want);
    end
  endtask

  task automatic test_game_over();
    pick(8'd0);
    pick(8'd1);
    m.rev = 16'h0003;
    m.bsy = 1'b1;
    done(1'b0, 8'd0, 8'd1);
    game_over = 1'b1;
    sb.push_back(m);
    tick();
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL go_enter: got %h want %h", got, want);
    end
    repeat (6) tick();
    game_over = 1'b0;
    sb.push_back(m);
    pick(8'd4);
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL go_frozen: got %h want %h", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
    m = '0;
    sb.push_back(m);
    #1;
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL async_reset: got %h want %h", got, want);
    end
  endtask

  task automatic test_timeout();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m.rev[6] = 1'b1;
    sb.push_back(m);
    pick(8'd6);
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL to_pick: got %h want %h", got, want);
    end
`ifdef PAIR_RESOLVER_TURN_TIMEOUT_EN
    sb.push_back(m);
    repeat (8) tick();
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL to_before: got %h want %h", got, want);
    end
    m.rev = '0;
    m.ply = 1'b1;
    sb.push_back(m);
    tick();
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL to_fire: got %h want %h", got, want);
    end
`else
    sb.push_back(m);
    repeat (1000) tick();
    want = sb.pop_front(); got = obs(); run++;
    if (got !== want) begin
      failed++;
      $display("FAIL to_none: got %h want %h", got, want);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pair();
    test_mismatch();
    test_invalid();
    test_same_sel();
    test_same_cycle();
    test_game_over();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", run, failed);
    $finish;
  end

endmodule
